// File: rtl/sfs_pkg.sv
// rtl/sfs_pkg.sv - shared types and widths for the sample fetch scheduler
package sfs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } sfs_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sample_fetch_scheduler_rr_pick.sv
// rtl/sample_fetch_scheduler_rr_pick.sv - combinational round-robin pick
module rr_pick
    import sfs_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int IW = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [IW-1:0]     rr_ptr,
    output logic              found,
    output logic [NUM_CH-1:0] onehot,
    output logic [IW-1:0]     idx
);

    int          c;
    logic [IW-1:0] sel;

    // Scan from rr_ptr upward, wrapping, and keep the first eligible channel.
    always_comb begin
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        c      = 0;
        sel    = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            c = int'(rr_ptr) + j;
            if (c >= NUM_CH) c = c - NUM_CH;
            sel = IW'(c);
            if (!found && elig[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
        onehot[idx] = found;
    end

endmodule

// File: rtl/sample_fetch_scheduler.sv
// rtl/sample_fetch_scheduler.sv - per-frame round-robin sample-memory fetch scheduler
module sample_fetch_scheduler
    import sfs_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int CH_IDX_W = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    output logic [NUM_CH-1:0]        gnt,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     rd_valid,
    output logic [CH_IDX_W-1:0]      rd_ch,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     frame_done,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    sfs_state_t            state;
    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     elig;
    logic [NUM_CH-1:0]     pick_oh;
    logic [NUM_CH-1:0]     pending_left;
    logic [CH_IDX_W-1:0]   rr_ptr;
    logic [CH_IDX_W-1:0]   pick_idx;
    logic [CH_IDX_W-1:0]   ptr_next;
    logic [CH_IDX_W-1:0]   gnt_idx;
    logic                  pick_found;
    logic [ADDR_W-1:0]     addr_arr [NUM_CH];
    logic [ADDR_W-1:0]     pick_addr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end

    assign elig         = pending & req;
    assign pending_left = pending & ~pick_oh;
    assign pick_addr    = addr_arr[pick_idx];
    assign ptr_next     = (pick_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_IDX_W'(1);

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            rr_ptr     <= '0;
            gnt        <= '0;
            gnt_idx    <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            rd_valid   <= 1'b0;
            rd_ch      <= '0;
            rd_data    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            gnt        <= '0;
            mem_rd_en  <= 1'b0;
            frame_done <= (state == DONE);
            rd_valid   <= mem_rd_en;
            if (mem_rd_en) begin
                rd_ch   <= gnt_idx;
                rd_data <= mem_rdata;
            end
            // A late tick must win over a simultaneous clear, so the clear goes first.
            if (overrun_clr) overrun <= 1'b0;
            if (sample_tick) begin
                if (state != IDLE) overrun <= 1'b1;
                pending <= ch_en;
                state   <= (ch_en == '0) ? DONE : SERVE;
            end else begin
                case (state)
                    SERVE: begin
                        if (pick_found) begin
                            gnt       <= pick_oh;
                            gnt_idx   <= pick_idx;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= pick_addr;
                            pending   <= pending_left;
                            rr_ptr    <= ptr_next;
                            if (pending_left == '0) state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_fetch_scheduler.sv
// tb/tb_sample_fetch_scheduler.sv - self-checking bench for sample_fetch_scheduler
module tb_sample_fetch_scheduler;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sample_tick;
    logic [N-1:0]    ch_en;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic            rd_valid;
    logic [CW-1:0]   rd_ch;
    logic [DW-1:0]   rd_data;
    logic            frame_done;
    logic            overrun;
    logic            overrun_clr;

    logic [DW-1:0]   memtab [64];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            ph;
    int            m_ptr;
    bit            m_pend [N];
    int            e_gidx;
    logic [AW-1:0] e_addr;
    bit            e_rdv;
    int            e_rdch;
    logic [AW-1:0] e_rdaddr;
    bit            e_fd;
    bit            e_ov;

    typedef struct {
        bit           tick;
        logic [N-1:0] en;
        logic [N-1:0] rq;
        logic [N-1:0] e_gnt;
        logic [AW-1:0] e_addr;
        bit           e_rdv;
        int           e_rdch;
        bit           e_fd;
    } vec_t;

    vec_t tv [10];
    int   fa [4];

    sample_fetch_scheduler #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ch_en       (ch_en),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .rd_valid    (rd_valid),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    assign mem_rdata = memtab[mem_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_ptr = 0; e_gidx = -1; e_addr = '0;
        e_rdv = 0; e_rdch = 0; e_rdaddr = '0; e_fd = 0; e_ov = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    // One clock of the scheduling rules, evaluated on the inputs present before the edge.
    task automatic model_step();
        int pick;
        bit any;
        bit left;
        e_rdv = (e_gidx >= 0);
        if (e_gidx >= 0) begin
            e_rdch   = e_gidx;
            e_rdaddr = e_addr;
        end
        e_fd = (ph == 2);
        if (overrun_clr) e_ov = 0;
        e_gidx = -1;
        if (sample_tick) begin
            if (ph != 0) e_ov = 1;
            any = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = ch_en[i];
                any = any | ch_en[i];
            end
            ph = any ? 1 : 2;
        end else if (ph == 1) begin
            pick = -1;
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (pick < 0 && m_pend[c] && req[c]) pick = c;
            end
            if (pick >= 0) begin
                e_gidx = pick;
                e_addr = req_addr[pick*AW +: AW];
                m_pend[pick] = 0;
                m_ptr = (pick + 1) % N;
            end
            left = 0;
            for (int i = 0; i < N; i++) left = left | m_pend[i];
            if (!left) ph = 2;
        end else if (ph == 2) begin
            ph = 0;
        end
    endtask

    task automatic check_model();
        chk("model gnt", gnt, (e_gidx < 0) ? 0 : (1 << e_gidx));
        chk("model mem_rd_en", mem_rd_en, e_gidx >= 0);
        if (e_gidx >= 0) chk("model mem_addr", mem_addr, e_addr);
        chk("model rd_valid", rd_valid, e_rdv);
        if (e_rdv) begin
            chk("model rd_ch", rd_ch, e_rdch);
            chk("model rd_data", rd_data, memtab[e_rdaddr]);
        end
        chk("model frame_done", frame_done, e_fd);
        chk("model overrun", overrun, e_ov);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic wait_gnt(input string name, input logic [N-1:0] exp, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (gnt == '0 && k < budget);
        chk(name, gnt, exp);
    endtask

    task automatic wait_fd(input string name, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!frame_done && k < budget);
        chk(name, frame_done, 1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, " gnt"}, gnt, 0);
        chk({pfx, " mem_rd_en"}, mem_rd_en, 0);
        chk({pfx, " mem_addr"}, mem_addr, 0);
        chk({pfx, " rd_valid"}, rd_valid, 0);
        chk({pfx, " rd_ch"}, rd_ch, 0);
        chk({pfx, " rd_data"}, rd_data, 0);
        chk({pfx, " frame_done"}, frame_done, 0);
        chk({pfx, " overrun"}, overrun, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) memtab[i] = 16'(16'h5A00 + i * 257);
        fa = '{3, 10, 20, 63};
        sample_tick = 0; ch_en = '0; req = '0; req_addr = '0; overrun_clr = 0;
        model_reset();

        // Reset state, then idle with no tick
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle no gnt", gnt, 0);
        end

        // Full frame then an empty frame, table driven
        req_addr = {6'd63, 6'd20, 6'd10, 6'd3};
        tv[0] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 6'd0,  1'b0, 0, 1'b0};
        tv[1] = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 6'd3,  1'b0, 0, 1'b0};
        tv[2] = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 6'd10, 1'b1, 0, 1'b0};
        tv[3] = '{1'b0, 4'b1111, 4'b1111, 4'b0100, 6'd20, 1'b1, 1, 1'b0};
        tv[4] = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 6'd63, 1'b1, 2, 1'b0};
        tv[5] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 6'd0,  1'b1, 3, 1'b1};
        tv[6] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 6'd0,  1'b0, 0, 1'b0};
        tv[7] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 6'd0,  1'b0, 0, 1'b0};
        tv[8] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 6'd0,  1'b0, 0, 1'b1};
        tv[9] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 6'd0,  1'b0, 0, 1'b0};
        for (int v = 0; v < 10; v++) begin
            sample_tick = tv[v].tick;
            ch_en       = tv[v].en;
            req         = tv[v].rq;
            step();
            chk($sformatf("vec%0d gnt", v), gnt, tv[v].e_gnt);
            if (tv[v].e_gnt != '0) chk($sformatf("vec%0d mem_addr", v), mem_addr, tv[v].e_addr);
            chk($sformatf("vec%0d rd_valid", v), rd_valid, tv[v].e_rdv);
            if (tv[v].e_rdv) begin
                chk($sformatf("vec%0d rd_ch", v), rd_ch, tv[v].e_rdch);
                chk($sformatf("vec%0d rd_data", v), rd_data, memtab[fa[tv[v].e_rdch]]);
            end
            chk($sformatf("vec%0d frame_done", v), frame_done, tv[v].e_fd);
        end
        sample_tick = 0;

        // Round-robin: leave rr_ptr at 3, then ch0 must beat ch2
        ch_en = 4'b0100; req = 4'b0100; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("rr ch2 alone", 4'b0100, 10);
        req = '0;
        wait_fd("rr frame A done", 10);
        ch_en = 4'b0101; req = 4'b0101; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("rr ch0 wraps first", 4'b0001, 10);
        wait_gnt("rr ch2 second", 4'b0100, 10);
        req = '0;
        wait_fd("rr frame B done", 10);

        // Late requester stalls then completes the frame
        ch_en = 4'b0011; req = 4'b0001; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("late ch0", 4'b0001, 10);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("late stall no gnt", gnt, 0);
        end
        req = 4'b0010;
        wait_gnt("late ch1", 4'b0010, 10);
        req = '0;
        wait_fd("late frame done", 10);

        // Overrun: stalled frame hit by a new tick
        ch_en = 4'b0011; req = 4'b0001; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("ovr first ch0", 4'b0001, 10);
        req = '0;
        repeat (4) step();
        chk("ovr not yet", overrun, 0);
        sample_tick = 1;
        step();
        sample_tick = 0;
        chk("ovr set", overrun, 1);
        req = 4'b0001;
        wait_gnt("ovr restart ch0", 4'b0001, 10);
        req = '0;
        overrun_clr = 1;
        step();
        overrun_clr = 0;
        chk("ovr cleared", overrun, 0);
        sample_tick = 1; overrun_clr = 1;
        step();
        sample_tick = 0; overrun_clr = 0;
        chk("ovr set beats clr", overrun, 1);
        req = 4'b0011;
        wait_fd("ovr frame done", 20);
        req = '0;
        overrun_clr = 1;
        step();
        overrun_clr = 0;

        // Reset in the cycle after a grant drops the in-flight read
        ch_en = 4'b0010; req = 4'b0010; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("rst ch1 gnt", 4'b0010, 10);
        rst_n = 0;
        #1;
        model_reset();
        chk_zero("midreset");
        @(posedge clk);
        #1;
        chk("midreset no rd_valid", rd_valid, 0);
        req = '0;
        rst_n = 1;
        step();
        ch_en = 4'b1111; req = 4'b1111; sample_tick = 1;
        step();
        sample_tick = 0;
        wait_gnt("post reset starts ch0", 4'b0001, 10);
        wait_fd("post reset frame done", 10);
        req = '0;
        step();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample_tick = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) ch_en = N'($urandom);
            overrun_clr = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
                else if (!gnt[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
